// File: rtl/sub_serial.sv
// sub_serial: digit-serial unsigned subtractor Z = X - Y - bin, LSD first, valid/ready on both sides.
// Optional zero/ovf result flags are enabled with the SUB_FLAGS_EN macro.
module sub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Z,
    output logic             bout,
    output logic             busy
`ifdef SUB_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_x, r_y, r_acc;
    logic             r_b;
    logic [CW-1:0]    r_cnt;
    logic [DIGIT:0]   w_diff;
    logic [WIDTH-1:0] w_acc;
    logic             w_last, w_accept;
`ifdef SUB_FLAGS_EN
    logic             r_xm, r_ym;
`endif

    // One extra bit on the digit difference captures the outgoing borrow.
    assign w_diff   = {1'b0, r_x[DIGIT-1:0]} - {1'b0, r_y[DIGIT-1:0]} - {{DIGIT{1'b0}}, r_b};
    assign w_acc    = {w_diff[DIGIT-1:0], r_acc[WIDTH-1:DIGIT]};
    assign w_last   = r_cnt == CW'(N - 1);
    assign w_accept = in_valid & in_ready;

    always_comb begin
        w_next    = r_state;
        in_ready  = r_state == IDLE;
        out_valid = r_state == DONE;
        busy      = r_state != IDLE;
        if (r_state == IDLE && in_valid)
            w_next = RUN;
        else if (r_state == RUN && w_last)
            w_next = DONE;
        else if (r_state == DONE && out_ready)
            w_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_acc   <= '0;
            r_b     <= 1'b0;
            r_cnt   <= '0;
            Z       <= '0;
            bout    <= 1'b0;
`ifdef SUB_FLAGS_EN
            r_xm    <= 1'b0;
            r_ym    <= 1'b0;
            zero    <= 1'b0;
            ovf     <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_x   <= X;
                r_y   <= Y;
                r_b   <= bin;
                r_cnt <= '0;
`ifdef SUB_FLAGS_EN
                r_xm  <= X[WIDTH-1];
                r_ym  <= Y[WIDTH-1];
`endif
            end else if (r_state == RUN) begin
                r_x   <= r_x >> DIGIT;
                r_y   <= r_y >> DIGIT;
                r_acc <= w_acc;
                r_b   <= w_diff[DIGIT];
                r_cnt <= r_cnt + CW'(1);
                if (w_last) begin
                    Z    <= w_acc;
                    bout <= w_diff[DIGIT];
`ifdef SUB_FLAGS_EN
                    zero <= w_acc == '0;
                    ovf  <= (r_xm ^ r_ym) & (w_acc[WIDTH-1] ^ r_xm);
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_sub_serial.sv
// tb_sub_serial: directed plus random checks of sub_serial against an arithmetic reference.
// Build with SUB_FLAGS_EN defined to also check the zero/ovf flags.
module tb_sub_serial;
    logic       clk = 1'b0;
    logic       rst, in_valid, out_ready, bin;
    logic [7:0] X, Y;
    logic       in_ready, out_valid, bout, busy;
    logic [7:0] Z;
`ifdef SUB_FLAGS_EN
    logic       zero, ovf;
`endif
    int total = 0;
    int bad = 0;

    sub_serial #(.WIDTH(8), .DIGIT(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .X(X), .Y(Y), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .Z(Z), .bout(bout), .busy(busy)
`ifdef SUB_FLAGS_EN
        , .zero(zero), .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full operation: present operands, check latency, hold DONE for 'stall' cycles, handshake.
    task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic b, input int stall);
        int n;
        int d;
        logic [7:0] ez;
        logic eb;
        d  = int'(x) - int'(y) - int'(b);
        ez = 8'(d);
        eb = d < 0;
        chk("idle_ready", in_ready, 1);
        X = x; Y = y; bin = b; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; X = 8'($urandom); Y = 8'($urandom); bin = 1'($urandom);
        chk("ready_low", in_ready, 0);
        chk("busy_run", busy, 1);
        n = 1;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("latency", n, 5);
        chk("z", Z, ez);
        chk("bout", bout, eb);
`ifdef SUB_FLAGS_EN
        chk("zero", zero, ez == 8'h00);
        chk("ovf", ovf, (($signed(x) - $signed(y) - int'(b)) < -128) || (($signed(x) - $signed(y) - int'(b)) > 127));
`endif
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1; X = 8'($urandom); Y = 8'($urandom);
            tick();
            chk("hold_valid", out_valid, 1);
            chk("hold_z", Z, ez);
            chk("hold_bout", bout, eb);
            chk("hold_ready", in_ready, 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_valid", out_valid, 0);
        chk("post_ready", in_ready, 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; X = '0; Y = '0; bin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'($urandom); out_ready = 1'($urandom);
            X = 8'($urandom); Y = 8'($urandom); bin = 1'($urandom);
            tick();
            chk("rst_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_z", Z, 0);
            chk("rst_bout", bout, 0);
`ifdef SUB_FLAGS_EN
            chk("rst_zero", zero, 0);
            chk("rst_ovf", ovf, 0);
`endif
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        chk("rst_ready", in_ready, 1);

        do_op(8'h35, 8'h12, 1'b0, 0);
        do_op(8'h00, 8'h01, 1'b0, 0);
        do_op(8'h80, 8'h01, 1'b0, 0);
        do_op(8'h10, 8'h0F, 1'b1, 0);
        do_op(8'hFF, 8'hFF, 1'b1, 1);

        // Backpressure with new operands waiting; they are taken only after the handshake.
        do_op(8'h5A, 8'h3C, 1'b0, 6);
        do_op(8'hC3, 8'h7E, 1'b1, 0);

        // Abort in the second RUN cycle.
        X = 8'h77; Y = 8'h11; bin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ready", in_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_z", Z, 0);
        begin
            int seen = 0;
            for (int i = 0; i < 8; i++) begin
                out_ready = 1'b1;
                tick();
                if (out_valid) seen++;
            end
            out_ready = 1'b0;
            chk("abort_no_valid", seen, 0);
        end
        do_op(8'hA0, 8'h0A, 1'b0, 0);

        for (int i = 0; i < 20; i++)
            do_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sub_serial.md
# sub_serial

Multi-cycle, digit-serial unsigned subtractor that computes X − Y − bin over WIDTH bits. It processes DIGIT bits per clock, least-significant digit first, and chains the borrow through a register between cycles. It is the subtract-side companion to the team's ripple-carry adder chain. It sits behind a valid/ready operand handshake and returns the registered difference and borrow-out on a valid/ready result handshake.

## Interface
- WIDTH, 8, operand and result width; must be a multiple of DIGIT.
- DIGIT, 2, bits processed per cycle; N = WIDTH/DIGIT cycles per operation.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands X, Y, bin are valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- X  in  WIDTH  minuend, unsigned.
- Y  in  WIDTH  subtrahend, unsigned.
- bin  in  1  borrow-in.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- Z  out  WIDTH  (X − Y − bin) mod 2^WIDTH, registered.
- bout  out  1  borrow-out: 1 if X < Y + bin, unsigned.
- busy  out  1  high in RUN or DONE.
- zero, ovf  out  1 each  present only with SUB_FLAGS_EN (see Configuration).

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch X, Y and bin into shift registers, preload the borrow register with bin, clear the digit counter, and go to RUN.
- RUN:
  - Each edge subtracts the low DIGIT bits of the latched X and Y using the borrow register.
  - The difference digit shifts into the Z shift register from the MSB side; the borrow register updates to the new borrow.
  - Operand registers shift right by DIGIT; the counter increments.
  - On the edge where counter = N−1: load Z and bout, and go to DONE.
- DONE:
  - out_valid = 1; Z and bout stay stable.
  - On out_valid & out_ready, go to IDLE.
- Only one operation is in flight at a time.
  - in_valid is ignored outside IDLE.
  - Changes to X, Y and bin after acceptance have no effect.
- All arithmetic is unsigned modulo 2^WIDTH, and the borrow chains across digits exactly as in a WIDTH-bit ripple subtract.
- Reset mid-operation:
  - The state returns to IDLE on the next edge and any partial result is discarded.
  - out_valid is never raised for the aborted operation.

## Timing
- Reset values: in_ready = 1 once rst deasserts; out_valid = 0; busy = 0; Z = 0; bout = 0; zero = 0; ovf = 0. The internal counter and borrow register are 0.
- Latency:
  - Operands are accepted at edge E0.
  - out_valid rises in the cycle after edge E0+N, i.e. N+1 edges after acceptance.
  - With the defaults, N = 4.
- Throughput: one result every N+2 cycles when out_ready is held high. The extra cycles are the DONE handshake and the return to IDLE.
- in_ready deasserts the cycle after acceptance and reasserts the cycle after the result handshake.
- Backpressure: DONE holds indefinitely while out_ready = 0, and all outputs stay stable.
- Simultaneous rst and a handshake: rst wins, and neither transfer is considered to have completed.

## Configuration
- SUB_FLAGS_EN defined:
  - The zero and ovf ports exist and are registered together with Z.
  - zero = (Z == 0).
  - ovf = signed two's-complement overflow of X − Y − bin, i.e. X[MSB] ≠ Y[MSB] and Z[MSB] ≠ X[MSB].
  - Both flags are 0 at reset and are valid only while out_valid = 1.
- SUB_FLAGS_EN undefined: the zero and ovf ports and their logic are absent; all other behaviour is identical.

## Test plan
All scenarios use WIDTH = 8 and DIGIT = 2.
- Reset: hold rst for 3 cycles with random inputs → out_valid = 0, busy = 0, Z = 0, bout = 0; in_ready = 1 in the first cycle after rst deasserts.
- Basic subtract: X = 8'h35, Y = 8'h12, bin = 0 → Z = 8'h23, bout = 0; out_valid rises exactly 5 edges after acceptance.
- Underflow: X = 8'h00, Y = 8'h01, bin = 0 → Z = 8'hFF, bout = 1. With SUB_FLAGS_EN: zero = 0, ovf = 0.
- Flags (SUB_FLAGS_EN):
  - X = 8'h80, Y = 8'h01, bin = 0 → Z = 8'h7F, bout = 0, ovf = 1.
  - X = 8'h10, Y = 8'h0F, bin = 1 → Z = 8'h00, bout = 0, zero = 1.
- Backpressure: hold out_ready = 0 for 6 cycles in DONE while in_valid = 1 with new operands → Z, bout and out_valid stay stable and in_ready = 0. When out_ready rises, the result handshake completes; the next accepted operation is the new operands and yields the correct result.
- Abort: assert rst for 1 cycle during the 2nd RUN cycle → IDLE on the next cycle and out_valid is never raised. A following X = 8'hA0, Y = 8'h0A, bin = 0 → Z = 8'h96, bout = 0.
